inv_pipe: RTL and testbench

Parametrised successor to the single-bit inverter cell: a WIDTH-bit elastic pipeline with a valid/ready handshake at each end and a programmable per-lane polarity mask.
- A lane whose mask bit is 1 leaves inverted; a lane whose mask bit is 0 passes through unchanged.
- Used where registered, polarity-configurable bus inversion is needed between handshaked blocks.
- Carries data DEPTH stages deep, sustaining one beat per cycle under backpressure without loss.

---
 rtl/inv_pkg.sv | 31 +++
 rtl/inv_pipe_stage.sv | 59 +++++
 rtl/inv_pipe.sv | 106 ++++++++++
 tb/tb_inv_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_pkg.sv
// -----------------------------------------------------------------------------
// inv_pkg
// Shared constants and helpers for the inv_pipe polarity-inverting pipeline.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default lane count and stage count
//   all_ones_mask()               : builds the all-ones reset polarity mask
//   cfg_ok()                      : legality of a WIDTH/DEPTH pair
// -----------------------------------------------------------------------------
package inv_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 2;

    // Upper bound for the generic mask helper; callers cast down to WIDTH.
    localparam int MAX_WIDTH = 1024;

    function automatic logic [MAX_WIDTH-1:0] all_ones_mask(input int unsigned width);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
            if (b < width) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic bit cfg_ok(input int width, input int depth);
        return (width >= 1) && (width <= MAX_WIDTH) && (depth >= 1);
    endfunction

endpackage

// File: rtl/inv_pipe_stage.sv
// -----------------------------------------------------------------------------
// inv_pipe_stage
// One valid+data register of the elastic pipeline. The load decision is made
// by the parent (it depends on the whole downstream valid chain); this cell
// only captures the upstream beat when told to.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : this stage takes the upstream content at the next edge
//   up_valid_i   : upstream stage (or input port) holds a beat
//   up_data_i    : upstream data
//   valid_o      : this stage holds a beat
//   data_o       : this stage's data
// -----------------------------------------------------------------------------
module inv_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            // Loading an empty upstream slot simply clears this stage, which
            // is how bubbles collapse toward the output.
            valid_d = up_valid_i;
            // Data only changes when a real beat arrives, so nq never shows
            // don't-care input values.
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; data is reset as well because
    // nq must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/inv_pipe.sv
// -----------------------------------------------------------------------------
// inv_pipe
// WIDTH-bit elastic pipeline, DEPTH register stages deep, that inverts each
// lane whose polarity mask bit is 1 and passes the others through.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : upstream beat present
//   in_ready   : pipeline accepts a beat this cycle (combinational from
//                out_ready through the stage valid chain)
//   i          : input data
//   out_valid  : output beat present
//   out_ready  : downstream accepts the beat
//   nq         : output data, i ^ mask captured at accept
//   mask_we    : load mask_d into the polarity mask at the edge
//   mask_d     : new polarity mask
//   mask_q     : current polarity mask
// -----------------------------------------------------------------------------
module inv_pipe
    import inv_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter int               DEPTH    = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] MASK_RST = WIDTH'(all_ones_mask(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] nq,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_d,
    output logic [WIDTH-1:0] mask_q
);

    if (!cfg_ok(WIDTH, DEPTH)) begin : g_bad_cfg
        $error("inv_pipe: WIDTH and DEPTH must both be >= 1");
    end

    // -------------------------------------------------------------------------
    // Polarity mask. The input XOR reads mask_q, i.e. the pre-write value, so a
    // beat accepted in the same cycle as a write still uses the old mask.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= MASK_RST;
        end else if (mask_we) begin
            mask_q <= mask_d;
        end
    end

    // -------------------------------------------------------------------------
    // Load chain: a stage loads when it is empty or when its content moves on,
    // and its content moves on when the next stage loads (the last stage moves
    // on when out_ready is high). Walked from the output backwards.
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_load;
    logic [WIDTH-1:0] stage_data [DEPTH];

    always_comb begin : p_load_chain
        logic moves_on;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        stage_load = '0;
        moves_on   = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            stage_load[k] = !stage_valid[k] || moves_on;
            moves_on      = stage_load[k];
        end
    end

    // -------------------------------------------------------------------------
    // Stage registers
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = i ^ mask_q;
        end else begin : g_body
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[k-1];
        end

        inv_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .load_i     (stage_load[k]),
            .up_valid_i (up_valid),
            .up_data_i  (up_data),
            .valid_o    (stage_valid[k]),
            .data_o     (stage_data[k])
        );
    end

    assign in_ready  = stage_load[0];
    assign out_valid = stage_valid[DEPTH-1];
    assign nq        = stage_data[DEPTH-1];

endmodule

// File: tb/tb_inv_pipe.sv
// -----------------------------------------------------------------------------
// tb_inv_pipe
// Scoreboard bench for inv_pipe (WIDTH=8, DEPTH=2). The monitor predicts each
// accepted beat as i ^ mask (mask as it stood before that edge), queues it, and
// compares in order when the DUT emits. Ready is predicted from occupancy: the
// pipeline can take a beat if fewer than DEPTH beats are held or one leaves.
// -----------------------------------------------------------------------------
module tb_inv_pipe;

    localparam int               WIDTH    = 8;
    localparam int               DEPTH    = 2;
    localparam logic [WIDTH-1:0] MASK_RST = 8'hFF;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] nq;
    logic             mask_we;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] mask_q;

    inv_pipe #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .MASK_RST (MASK_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i         (i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .nq        (nq),
        .mask_we   (mask_we),
        .mask_d    (mask_d),
        .mask_q    (mask_q)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model / scoreboard
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] out_log[$];
    logic [WIDTH-1:0] model_mask = MASK_RST;
    int               n_acc  = 0;
    int               n_emit = 0;
    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] hold_nq   = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_mask = MASK_RST;
            hold_prev  = 1'b0;
        end else begin
            check("in_ready", 64'(in_ready),
                  64'((exp_q.size() < DEPTH) || out_ready));
            check("mask_q", 64'(mask_q), 64'(model_mask));
            if (hold_prev) begin
                check("stall_valid_hold", 64'(out_valid), 64'(1));
                check("stall_nq_hold", 64'(nq), 64'(hold_nq));
            end
            if (out_valid && out_ready) begin
                n_emit++;
                out_log.push_back(nq);
                check("beat_was_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    check("out_data", 64'(nq), 64'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                exp_q.push_back(i ^ model_mask);
            end
            if (mask_we) begin
                model_mask = mask_d;
            end
            hold_prev = out_valid && !out_ready;
            hold_nq   = nq;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        mask_we   = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        check("drain_within_budget", 64'(n < 50), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int acc0, emit0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        i         = '0;
        out_ready = 1'b0;
        mask_we   = 1'b0;
        mask_d    = '0;

        // 1. Reset state
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_nq", 64'(nq), 64'(0));
        check("rst_mask_q", 64'(mask_q), 64'(8'hFF));
        rst = 1'b0;
        settle();
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        step();

        // 2. Streaming with out_ready held high, latency of two edges
        out_log.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        i         = 8'h00;
        step();
        check("stream_lat_not_yet", 64'(out_valid), 64'(0));
        i = 8'hA5;
        step();
        check("stream_first_valid", 64'(out_valid), 64'(1));
        check("stream_first_nq", 64'(nq), 64'(8'hFF));
        i = 8'h0F;
        step();
        check("stream_second_nq", 64'(nq), 64'(8'h5A));
        in_valid = 1'b0;
        step();
        check("stream_third_nq", 64'(nq), 64'(8'hF0));
        step();
        check("stream_done_valid", 64'(out_valid), 64'(0));
        check("stream_count", 64'(out_log.size()), 64'(3));

        // 3. Backpressure: two accepted, third waits until out_ready rises
        drain();
        out_log.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        i         = 8'h11;
        settle();
        check("bp_ready_first", 64'(in_ready), 64'(1));
        step();
        i = 8'h22;
        settle();
        check("bp_ready_second", 64'(in_ready), 64'(1));
        step();
        i = 8'h33;
        settle();
        check("bp_ready_full", 64'(in_ready), 64'(0));
        step();
        check("bp_still_full", 64'(in_ready), 64'(0));
        check("bp_head_nq", 64'(nq), 64'(8'hEE));
        out_ready = 1'b1;
        settle();
        check("bp_ready_on_release", 64'(in_ready), 64'(1));
        step();
        drain();
        check("bp_count", 64'(out_log.size()), 64'(3));
        if (out_log.size() == 3) begin
            check("bp_order0", 64'(out_log[0]), 64'(8'hEE));
            check("bp_order1", 64'(out_log[1]), 64'(8'hDD));
            check("bp_order2", 64'(out_log[2]), 64'(8'hCC));
        end

        // 4. Mask write in the same cycle as an accept
        out_log.delete();
        in_valid = 1'b1;
        i        = 8'h33;
        mask_we  = 1'b1;
        mask_d   = 8'h0F;
        step();
        mask_we = 1'b0;
        check("mask_written", 64'(mask_q), 64'(8'h0F));
        step();
        drain();
        check("mask_count", 64'(out_log.size()), 64'(2));
        if (out_log.size() == 2) begin
            check("mask_old_used", 64'(out_log[0]), 64'(8'hCC));
            check("mask_new_used", 64'(out_log[1]), 64'(8'h3C));
        end

        // 5. Full pipeline, simultaneous accept and emit for 10 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        i         = 8'h5C;
        step();
        i = 8'hC5;
        step();
        settle();
        check("full_before_flow", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        acc0  = n_acc;
        emit0 = n_emit;
        for (int c = 0; c < 10; c++) begin
            i = 8'($urandom);
            settle();
            check("flow_in_ready", 64'(in_ready), 64'(1));
            step();
        end
        in_valid = 1'b0;
        check("flow_accepts", 64'(n_acc - acc0), 64'(10));
        check("flow_emits", 64'(n_emit - emit0), 64'(10));
        drain();

        // 6. Reset with beats in flight and a changed mask
        mask_we = 1'b1;
        mask_d  = 8'h5A;
        step();
        mask_we   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        i         = 8'h01;
        step();
        i = 8'h02;
        step();
        in_valid = 1'b0;
        settle();
        check("pre_rst_out_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        settle();
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_nq", 64'(nq), 64'(0));
        check("midrst_mask_q", 64'(mask_q), 64'(8'hFF));
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        out_log.delete();
        repeat (6) step();
        check("no_stale_beats", 64'(out_log.size()), 64'(0));

        // 7. Random traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            i         = 8'($urandom);
            mask_we   = ($urandom_range(0, 7) == 0);
            mask_d    = 8'($urandom);
            step();
        end
        drain();
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
